soc_spi_master: RTL and testbench
=================================

Name: soc_spi_master

Overview:
- Wishbone slave that sits directly downstream of the SoC bus bridge, on one of its `wb_cyc[x]` slots (window 0x8x000000).
- Gives the CPU byte-wise SPI mode-0 access to the config flash: a programmable SCK divider, software-controlled chip select, and single-byte full-duplex shifts.
- Read data is zero whenever `wb_ack` is low, so the bridge can OR-combine `rdata` across all slaves.

Parameters:
- `DIV_WIDTH`, 8, width of the SCK half-period divider field.
- `DIV_RST`, 8'hff, divider value loaded at reset.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `wb_addr`  in  4  word address; only [1:0] decoded, [3:2] ignored
- `wb_rdata`  out  32  read data; 0 when `wb_ack`=0
- `wb_wdata`  in  32  write data
- `wb_we`  in  1  write enable
- `wb_cyc`  in  1  cycle/select from bridge
- `wb_ack`  out  1  single-cycle acknowledge
- `spi_mosi`  out  1  serial data out
- `spi_miso`  in  1  serial data in (already synchronised at pad)
- `spi_clk`  out  1  SCK, idle low (mode 0)
- `spi_cs_n`  out  1  chip select, active low

Behaviour:
- Interface fixed: one clock `clk`; `rst` synchronous, active-high.
- Reset values: `wb_ack`=0, `wb_rdata`=0, `spi_clk`=0, `spi_mosi`=0, `spi_cs_n`=1, divider=`DIV_RST`, rx byte=0, FSM=IDLE.
- Bus handshake:
  - `wb_ack` <= `wb_cyc` & ~`wb_ack`. The ack comes 1 cycle after `cyc` rises and lasts exactly 1 cycle.
  - The bridge drops `cyc` in the ack cycle. Back-to-back accesses therefore give ack every other cycle.
  - Write side effects happen in the cycle `wb_ack` is asserted, exactly once per access. `wb_rdata` is registered alongside `wb_ack`.
  - `wb_wmsk` is not connected; all writes are full-word.
- Register map (word address):
  - 0 CSR, RW:
    - [0] = `cs_n` drive value.
    - [DIV_WIDTH+7:8] = div.
    - Read-only [31] = busy.
    - Writes to CSR while busy update only `cs_n`; div is held.
  - 1 DATA:
    - Write [7:0] = tx byte, starts a transfer if not busy. A write while busy is acked and discarded.
    - Read [7:0] = last rx byte, [31] = busy, others 0.
  - 2, 3: read 0; writes ignored (still acked).
- FSM: IDLE -> LOW -> HIGH -> LOW ... -> IDLE.
  - Half-period counter runs 0..div, so each SCK phase lasts div+1 clocks.
  - Bit counter is 3 bits, counting 7 down to 0.
  - On the DATA write ack cycle N:
    - shift reg <= tx byte; busy=1 from N+1.
    - `spi_mosi` = tx[7] from N+1.
    - FSM enters LOW.
  - LOW end (counter == div): `spi_clk` <= 1, sample `spi_miso` into shift[0] after shifting left; go HIGH.
  - HIGH end: `spi_clk` <= 0.
    - If bit counter == 0: latch rx byte, go IDLE, busy=0.
    - Else: decrement bit counter, drive next MOSI bit, go LOW.
- Latency: busy for exactly 16*(div+1) cycles. With div=0, SCK = `clk`/2 and busy = 16 cycles.
- Boundaries:
  - div=0 is legal.
  - The counter wraps to 0 at every phase change.
  - `spi_cs_n` is purely software-driven and independent of the FSM; changing it mid-transfer is allowed and does not abort the shift.
  - A DATA read during a transfer returns the previous rx byte with bit31=1.
  - A DATA write in the same ack cycle that busy clears is accepted only if busy was already 0 at that clock edge; otherwise it is dropped.
- Reset mid-transfer: FSM returns to IDLE, `spi_clk`=0, `spi_cs_n`=1, rx byte cleared, all in the cycle after `rst`.

Decomposition:
- Shared package `soc_spi_pkg`:
  - register address constants: `SPI_REG_CSR`=0, `SPI_REG_DATA`=1.
  - CSR bit positions: CS=0, DIV_LSB=8, BUSY=31.
  - FSM state encoding: IDLE/LOW/HIGH.
- One natural sub-module, `soc_spi_shifter`: FSM, counters and shift register. The top holds the Wishbone decode and CSR.

Test Plan:
- Reset, then read CSR -> ack 1 cycle after `cyc`; `rdata`=0x0000ff01; `spi_cs_n`=1; `spi_clk`=0; `rdata` is 0 in every non-ack cycle.
- Write CSR=0x00000300, write DATA=0xA5 with MISO looped to MOSI -> `cs_n`=0; 8 SCK pulses, each phase 4 clocks; busy for 64 cycles; MOSI sequence 1,0,1,0,0,1,0,1; DATA read = 0x000000A5.
- div=0, MISO tied 1, write DATA=0x00 -> busy high for exactly 16 cycles; rx=0xFF; SCK toggles every clock.
- During a transfer of 0x3C, write DATA=0xFF and CSR div=0x10 -> both acked; MOSI still carries 0x3C; div reads back unchanged; second byte never sent.
- Assert `rst` at the 5th SCK edge of a transfer -> next cycle FSM is IDLE, `spi_clk`=0, `spi_cs_n`=1, busy=0, DATA read = 0.
- Read addresses 2 and 3, and write address 2 -> ack each time; `rdata`=0; no state change.

Source files
------------

// File: rtl/soc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_spi_pkg
// Description : Shared constants and FSM state encoding for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_spi_pkg;

    // Register word addresses (wb_addr[1:0])
    localparam logic [1:0] SPI_REG_CSR  = 2'd0;
    localparam logic [1:0] SPI_REG_DATA = 2'd1;

    // CSR bit positions
    localparam int CSR_CS      = 0;
    localparam int CSR_DIV_LSB = 8;
    localparam int CSR_BUSY    = 31;

    // Shifter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_t;

endpackage : soc_spi_pkg
`default_nettype wire

// File: rtl/soc_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : soc_spi_shifter
// Description : Mode-0 byte shifter: SCK phase timing, bit counter and
//               full-duplex shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_spi_shifter
    import soc_spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 spi_miso,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 busy,
    output logic [7:0]           rx_byte
);

    spi_state_t           r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [7:0]           r_rx, w_rx_nxt;
    logic                 r_sck, w_sck_nxt;
    logic                 r_mosi, w_mosi_nxt;
    logic                 w_phase_end;

    assign w_phase_end = (r_cnt == div);

    // State and datapath registers; reset returns everything to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_rx    <= 8'h00;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_rx    <= w_rx_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
        end
    end

    // Next-state logic: each SCK phase lasts div+1 clocks, MSB first
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_rx_nxt    = r_rx;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd7;
                    w_shift_nxt = tx_byte;
                    w_mosi_nxt  = tx_byte[7];
                end
            end
            ST_LOW: begin
                if (w_phase_end) begin
                    // Rising SCK: capture MISO into the vacated LSB
                    w_sck_nxt   = 1'b1;
                    w_shift_nxt = {r_shift[6:0], spi_miso};
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_phase_end) begin
                    w_sck_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd0) begin
                        w_rx_nxt    = r_shift;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // After the left shift, bit 7 holds the next TX bit
                        w_bit_nxt   = r_bit - 3'd1;
                        w_mosi_nxt  = r_shift[7];
                        w_state_nxt = ST_LOW;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign spi_clk  = r_sck;
    assign spi_mosi = r_mosi;
    assign busy     = (r_state != ST_IDLE);
    assign rx_byte  = r_rx;

endmodule : soc_spi_shifter
`default_nettype wire

// File: rtl/soc_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : soc_spi_master
// Description : Wishbone slave giving byte-wise SPI mode-0 access to the
//               config flash (CSR + DATA registers, software chip select).
// Revision    : 1.0 - initial release
// ============================================================================
module soc_spi_master
    import soc_spi_pkg::*;
#(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RST   = 8'hff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_addr,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_clk,
    output logic        spi_cs_n
);

    logic                 r_ack;
    logic [31:0]          r_rdata;
    logic                 r_pend_we;
    logic [1:0]           r_pend_addr;
    logic [31:0]          r_pend_wdata;
    logic                 r_cs_n;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_req;
    logic                 w_busy;
    logic [7:0]           w_rx;
    logic [31:0]          w_read_data;
    logic                 w_wr_csr;
    logic                 w_start;
    logic                 w_unused;

    // A request is the first cycle of cyc; the ack follows one clock later
    assign w_req = wb_cyc & ~r_ack;

    // Write side effects land at the end of the ack cycle, using the busy
    // value seen during that cycle
    assign w_wr_csr = r_ack & r_pend_we & (r_pend_addr == SPI_REG_CSR);
    assign w_start  = r_ack & r_pend_we & (r_pend_addr == SPI_REG_DATA) & ~w_busy;

    // Address decode for read data; only wb_addr[1:0] is significant
    always_comb begin
        w_read_data = 32'h0;
        case (wb_addr[1:0])
            SPI_REG_CSR: begin
                w_read_data[CSR_CS]                        = r_cs_n;
                w_read_data[CSR_DIV_LSB +: DIV_WIDTH]      = r_div;
                w_read_data[CSR_BUSY]                      = w_busy;
            end
            SPI_REG_DATA: begin
                w_read_data[7:0]      = w_rx;
                w_read_data[CSR_BUSY] = w_busy;
            end
            default: w_read_data = 32'h0;
        endcase
    end

    // Bus handshake, request capture and CSR state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack        <= 1'b0;
            r_rdata      <= 32'h0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= 2'd0;
            r_pend_wdata <= 32'h0;
            r_cs_n       <= 1'b1;
            r_div        <= DIV_RST;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_req ? w_read_data : 32'h0;
            if (w_req) begin
                r_pend_we    <= wb_we;
                r_pend_addr  <= wb_addr[1:0];
                r_pend_wdata <= wb_wdata;
            end
            if (w_wr_csr) begin
                r_cs_n <= r_pend_wdata[CSR_CS];
                // Divider is frozen while a byte is on the wire
                if (!w_busy) begin
                    r_div <= r_pend_wdata[CSR_DIV_LSB +: DIV_WIDTH];
                end
            end
        end
    end

    soc_spi_shifter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .tx_byte  (r_pend_wdata[7:0]),
        .div      (r_div),
        .spi_miso (spi_miso),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .busy     (w_busy),
        .rx_byte  (w_rx)
    );

    assign wb_ack   = r_ack;
    assign wb_rdata = r_rdata;
    assign spi_cs_n = r_cs_n;

    // Upper address bits and unused write-data bits are intentionally ignored
    assign w_unused = &{1'b0, wb_addr[3:2], r_pend_wdata};

endmodule : soc_spi_master
`default_nettype wire

// File: tb/tb_soc_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_spi_master
// Description : Self-checking bench for soc_spi_master with a transfer-level
//               reference model (expected MOSI byte, RX byte and timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_clk;
    logic        spi_cs_n;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   miso_mode = 0;      // 0: loop MOSI back, 1: tie 0, 2: tie 1
    bit   bg_en = 1'b0;
    logic prev_ack = 1'b0;
    logic [7:0] last_rx = 8'h00;

    always #5 clk = ~clk;

    always_comb spi_miso = (miso_mode == 0) ? spi_mosi : (miso_mode == 2);

    soc_spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // rdata must be zero outside ack, and ack never lasts two cycles
    always @(negedge clk) begin
        if (bg_en) begin
            if (wb_ack !== 1'b1) check("rdata_idle", wb_rdata, 32'h0);
            check("ack_single", {31'b0, wb_ack & prev_ack}, 32'h0);
        end
        prev_ack = wb_ack;
    end

    task automatic wb_xfer(input logic we, input logic [3:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wd;
        check("ack_pre", {31'b0, wb_ack}, 32'h0);
        @(posedge clk); #1;
        check("ack", {31'b0, wb_ack}, 32'h1);
        rd = wb_rdata;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    // Called in the DATA-write ack cycle; observes SCK/MOSI from the next cycle
    task automatic monitor(input int div, output logic [7:0] bits,
                           output int total, output bit phases_ok);
        int   cyc_cnt = 0;
        int   rises = 0;
        int   plen = 0;
        logic prev = 1'b0;
        bit   done = 1'b0;
        bits = 8'h00; total = -1; phases_ok = 1'b1;
        @(negedge clk);
        while (!done && cyc_cnt < 16 * (div + 1) + 40) begin
            @(negedge clk);
            cyc_cnt++;
            if (spi_clk !== prev) begin
                if (plen != div + 1) phases_ok = 1'b0;
                plen = 0;
                if (spi_clk === 1'b1) begin
                    bits = {bits[6:0], spi_mosi};
                    rises++;
                end else if (rises == 8) begin
                    total = cyc_cnt - 1;
                    done = 1'b1;
                end
            end
            plen++;
            prev = spi_clk;
        end
        if (!done) check("monitor_timeout", 32'h1, 32'h0);
    endtask

    task automatic do_transfer(input int div, input logic [7:0] tx, input int mode);
        logic [31:0] rd;
        logic [7:0]  bits;
        logic [7:0]  exp_rx;
        int          total;
        bit          ok;
        miso_mode = mode;
        wb_xfer(1'b1, 4'h0, 32'(div) << 8, rd);
        wb_xfer(1'b1, 4'h1, {24'h0, tx}, rd);
        monitor(div, bits, total, ok);
        exp_rx = (mode == 0) ? tx : ((mode == 2) ? 8'hFF : 8'h00);
        check("mosi_seq", {24'h0, bits}, {24'h0, tx});
        check("busy_len", 32'(total), 32'(16 * (div + 1)));
        check("sck_phase", {31'b0, ok}, 32'h1);
        check("cs_n_low", {31'b0, spi_cs_n}, 32'h0);
        wb_xfer(1'b0, 4'h1, 32'h0, rd);
        check("rx_data", rd, {24'h0, exp_rx});
        last_rx = exp_rx;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  bits;
        int          total;
        int          edges;
        bit          ok;
        logic        prev_sck;

        rst = 1'b1; wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = 4'h0; wb_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, wb_ack}, 32'h0);
        check("rst_rdata", wb_rdata, 32'h0);
        check("rst_sck", {31'b0, spi_clk}, 32'h0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'h0);
        check("rst_cs_n", {31'b0, spi_cs_n}, 32'h1);
        rst = 1'b0;
        bg_en = 1'b1;

        // Reset CSR, also through an aliased address (upper bits ignored)
        wb_xfer(1'b0, 4'h0, 32'h0, rd);
        check("csr_reset", rd, 32'h0000ff01);
        wb_xfer(1'b0, 4'h4, 32'h0, rd);
        check("csr_alias", rd, 32'h0000ff01);

        // div=3 loopback byte, then div=0 with MISO tied high
        do_transfer(3, 8'hA5, 0);
        wb_xfer(1'b0, 4'h0, 32'h0, rd);
        check("csr_div3", rd, 32'h00000300);
        do_transfer(0, 8'h00, 2);

        // Randomized bytes, dividers and MISO modes
        for (int i = 0; i < 6; i++) begin
            do_transfer(int'($urandom_range(0, 2)), 8'($urandom), int'($urandom_range(0, 2)));
        end

        // Writes during a transfer: DATA dropped, CSR changes only cs_n
        miso_mode = 0;
        wb_xfer(1'b1, 4'h0, 32'h00000300, rd);
        wb_xfer(1'b1, 4'h1, 32'h0000003C, rd);
        fork
            monitor(3, bits, total, ok);
            begin
                repeat (2) @(posedge clk);
                wb_xfer(1'b1, 4'h1, 32'h000000FF, rd);
                wb_xfer(1'b1, 4'h0, 32'h00001001, rd);
                wb_xfer(1'b0, 4'h1, 32'h0, rd);
                check("data_busy_read", rd, {1'b1, 23'h0, last_rx});
                wb_xfer(1'b0, 4'h0, 32'h0, rd);
                check("csr_busy_read", rd, 32'h80000301);
                check("cs_n_mid", {31'b0, spi_cs_n}, 32'h1);
            end
        join
        check("mosi_3c", {24'h0, bits}, 32'h0000003C);
        check("busy_len_3c", 32'(total), 32'd64);
        edges = 0;
        repeat (80) begin
            @(negedge clk);
            if (spi_clk === 1'b1) edges++;
        end
        check("no_second_byte", 32'(edges), 32'h0);
        wb_xfer(1'b0, 4'h1, 32'h0, rd);
        check("rx_3c", rd, 32'h0000003C);
        last_rx = 8'h3C;
        wb_xfer(1'b0, 4'h0, 32'h0, rd);
        check("csr_after", rd, 32'h00000301);

        // Reset on the 5th SCK edge of a transfer
        wb_xfer(1'b1, 4'h1, 32'h00000096, rd);
        edges = 0;
        prev_sck = 1'b0;
        for (int c = 0; c < 100 && edges < 5; c++) begin
            @(negedge clk);
            if (spi_clk !== prev_sck) edges++;
            prev_sck = spi_clk;
        end
        check("sck_edges_seen", 32'(edges), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_sck", {31'b0, spi_clk}, 32'h0);
        check("mid_rst_cs_n", {31'b0, spi_cs_n}, 32'h1);
        wb_xfer(1'b0, 4'h0, 32'h0, rd);
        check("mid_rst_csr", rd, 32'h0000ff01);
        wb_xfer(1'b0, 4'h1, 32'h0, rd);
        check("mid_rst_data", rd, 32'h0);

        // Unmapped addresses: acked, read zero, no side effects
        wb_xfer(1'b0, 4'h2, 32'h0, rd);
        check("addr2_read", rd, 32'h0);
        wb_xfer(1'b0, 4'h3, 32'h0, rd);
        check("addr3_read", rd, 32'h0);
        wb_xfer(1'b1, 4'h2, 32'hFFFFFFFE, rd);
        wb_xfer(1'b0, 4'h0, 32'h0, rd);
        check("addr2_no_csr", rd, 32'h0000ff01);
        check("addr2_no_cs", {31'b0, spi_cs_n}, 32'h1);
        repeat (4) @(negedge clk);
        check("addr2_no_sck", {31'b0, spi_clk}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_soc_spi_master
`default_nettype wire
